// File: rtl/vctr_pkg.sv
// Shared types for the vector-engine job arbiter: FSM state encoding and
// pointer-width helper for requester indices.
package vctr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_LOAD,
        ST_WAIT,
        ST_DRAIN,
        ST_RELEASE
    } arb_state_t;

    // Index width for n requesters; never below 1 so single-bit ports stay legal.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// last_owner+1, wrapping. Returns a one-hot grant and its index.
module rr_pick
    import vctr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx
);

    int            p;
    logic [PW-1:0] pi;

    // Walk from farthest to nearest so the nearest set bit wins by overwrite.
    always_comb begin
        gnt = '0;
        idx = '0;
        p   = 0;
        pi  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            p  = (int'(last_owner) + k) % NUM_REQ;
            pi = PW'(p);
            if (req[pi]) begin
                gnt     = '0;
                gnt[pi] = 1'b1;
                idx     = pi;
            end
        end
    end

endmodule

// File: rtl/vctr_job_arbiter.sv
// Round-robin job scheduler sharing one vector-add engine among NUM_REQ
// requesters: grant, forward 2*VECTOR_LENGTH input beats, drain results, release.
module vctr_job_arbiter
    import vctr_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int VECTOR_LENGTH = 8,
    parameter int NUM_REQ       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_REQ-1:0]            out_rdy,
    output logic [NUM_REQ-1:0]            out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            job_done,
    output logic                          busy,
    output logic [15:0]                   job_cnt,
    output logic                          eng_start,
    output logic                          eng_data_in_en,
    output logic                          eng_data_out_en,
    output logic [DATA_WIDTH-1:0]         eng_data_in,
    input  logic                          eng_idle,
    input  logic                          eng_ready,
    input  logic                          eng_done,
    input  logic [DATA_WIDTH-1:0]         eng_data_out
);

    localparam int PW     = ptr_w(NUM_REQ);
    localparam int LOAD_N = 2 * VECTOR_LENGTH;
    localparam int LCW    = $clog2(LOAD_N + 1);
    localparam int DCW    = $clog2(VECTOR_LENGTH + 1);

    arb_state_t                           state, state_nx;
    logic [PW-1:0]                        owner, last_owner, pick_idx;
    logic [NUM_REQ-1:0]                   pick_gnt;
    logic [LCW-1:0]                       load_cnt;
    logic [DCW-1:0]                       pop_cnt;
    logic                                 pop, pop_q, accept;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   in_lane;

    assign in_lane = in_data;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .gnt        (pick_gnt),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= PW'(NUM_REQ - 1);
            load_cnt   <= '0;
            pop_cnt    <= '0;
            pop_q      <= 1'b0;
            job_cnt    <= '0;
        end else begin
            state <= state_nx;
            pop_q <= pop;
            if (state == ST_ARB && |req) begin
                gnt        <= pick_gnt;
                owner      <= pick_idx;
                last_owner <= pick_idx;
                load_cnt   <= '0;
                pop_cnt    <= '0;
            end
            if (accept) load_cnt <= load_cnt + 1'b1;
            if (pop)    pop_cnt  <= pop_cnt + 1'b1;
            if (state == ST_RELEASE) begin
                gnt     <= '0;
                job_cnt <= job_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        pop         = 1'b0;
        in_ready    = '0;
        job_done    = '0;
        eng_start   = 1'b0;
        eng_data_in = '0;
        case (state)
            ST_IDLE:    if (|req && eng_idle) state_nx = ST_ARB;
            ST_ARB:     state_nx = (|req) ? ST_START : ST_IDLE;
            ST_START: begin
                eng_start = eng_idle;
                if (eng_ready) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready    = eng_ready ? gnt : '0;
                accept      = eng_ready & in_valid[owner];
                eng_data_in = in_lane[owner];
                if (accept && load_cnt == LCW'(LOAD_N - 1)) state_nx = ST_WAIT;
            end
            ST_WAIT:    if (eng_done) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                // Pops stop after VECTOR_LENGTH; leave once the last popped beat is shown.
                pop = out_rdy[owner] && (pop_cnt != DCW'(VECTOR_LENGTH));
                if (pop_q && pop_cnt == DCW'(VECTOR_LENGTH)) state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
                job_done = gnt;
                state_nx = ST_IDLE;
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

    assign busy            = (state != ST_IDLE);
    assign eng_data_in_en  = accept;
    assign eng_data_out_en = pop;
    assign out_valid       = pop_q ? gnt : '0;
    assign out_data        = pop_q ? eng_data_out : '0;

endmodule

// File: doc/vctr_job_arbiter.md
# vctr_job_arbiter

Round-robin scheduler that shares one vector-add engine (two input vector FIFOs, one output vector FIFO, IDLE/READING/OPERATION/DONE handshake) among `NUM_REQ` requesters. It grants the engine to one requester per job, forwards that requester's 2×`VECTOR_LENGTH` input beats, waits for the result, drains `VECTOR_LENGTH` result beats back to the winner, then re-arbitrates. It sits between the requester-side stream ports and the engine's `start/ready/done/idle/data_in_en/data_out_en` pins.

## Interface
- `DATA_WIDTH`, 16, element width
- `VECTOR_LENGTH`, 8, elements per vector; also the engine FIFO depth
- `NUM_REQ`, 4, number of requesters (2..8)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `req` input NUM_REQ — job request per requester; level, held until `job_done` for that requester
- `in_valid` input NUM_REQ — input beat valid per requester
- `in_data` input NUM_REQ×DATA_WIDTH — packed input beats; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `in_ready` output NUM_REQ — beat accepted this cycle (granted requester only)
- `out_rdy` input NUM_REQ — requester can take a result beat
- `out_valid` output NUM_REQ — result beat on `out_data` for that requester
- `out_data` output DATA_WIDTH — shared result bus
- `gnt` output NUM_REQ — one-hot current owner, all-zero when unowned
- `job_done` output NUM_REQ — one-cycle pulse to owner when its job is released
- `busy` output 1 — state ≠ IDLE
- `job_cnt` output 16 — completed jobs, wraps at 2^16
- `eng_start`, `eng_data_in_en`, `eng_data_out_en` output 1; `eng_data_in` output DATA_WIDTH
- `eng_idle`, `eng_ready`, `eng_done` input 1; `eng_data_out` input DATA_WIDTH

## Operation
- States: IDLE, ARB, START, LOAD, WAIT, DRAIN, RELEASE.
- IDLE: if any `req` set and `eng_idle`, go to ARB.
- ARB: winner is the first set `req` bit searching from (last_owner+1) mod NUM_REQ upward; register `gnt` and set last_owner. Go to START. If `req` has meanwhile dropped to zero, return to IDLE.
- START: assert `eng_start` while `eng_idle`; go to LOAD once `eng_ready` is seen.
- LOAD: `in_ready[g] = eng_ready`; `eng_data_in_en = in_valid[g] & eng_ready`; `eng_data_in = in_data[g]`. The load counter counts accepted beats. After 2×VECTOR_LENGTH beats (first VECTOR_LENGTH go to vector A, the rest to vector B), deassert `in_ready` and go to WAIT.
- WAIT: wait for `eng_done`, then go to DRAIN.
- DRAIN: `eng_data_out_en = out_rdy[g]` until VECTOR_LENGTH pops have been issued. Each pop produces `out_valid[g]` one cycle later with `out_data = eng_data_out`. After the last `out_valid`, go to RELEASE.
- RELEASE: pulse `job_done[g]`; `job_cnt` += 1; clear `gnt`; go to IDLE.
- Requesters that are not granted see `in_ready`, `out_valid` and `job_done` at 0.
- `req[g]` dropping after ARB is ignored; the job runs to completion.
- Result arithmetic belongs to the engine (element-wise A+B mod 2^DATA_WIDTH). This block passes data through unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, last_owner = NUM_REQ−1 (so requester 0 wins first), counters 0.
- Latency from `req` to `gnt`: 2 cycles (IDLE→ARB→START, `gnt` registered at the ARB exit).
- `eng_start` is high for 1 cycle per job in the normal case.
- Input path is combinational pass-through: zero added latency, no buffering.
- Output path: `eng_data_out_en` to `out_valid` is exactly 1 cycle. When `out_rdy` is low, no pop is issued, so there is no loss.
- When multiple requesters assert `req` in the same cycle, round-robin order decides. A requester that holds `req` continuously waits at most NUM_REQ−1 other jobs.
- `rst` asserted mid-job returns the block to IDLE on the next edge and clears `gnt` and the counters. The engine is reset in the same cycle by the shared reset.
- The next arbitration cannot start before the engine reports `eng_idle`. Back-to-back jobs therefore have at least 2 idle cycles between `job_done` and the next `eng_start`.

## Structure
- Package `vctr_pkg`: the `arb_state_t` enum, and a `ptr_w = $clog2(NUM_REQ)` helper function.
- Sub-module `rr_pick`: combinational round-robin picker with inputs (`req`, `last_owner`) and outputs (one-hot `gnt`, index). It is reusable by other shared-resource schedulers.
- The FSM, counters and muxing live in `vctr_job_arbiter`.

## Test plan
- Single job: `req`=0001 with A=1..8 and B=10..80 → `gnt`=0001, 16 beats accepted, `out_data`=11,22,…,88 on `out_valid[0]`, one `job_done[0]` pulse, `job_cnt`=1.
- Contention: `req`=1111 held for 4 jobs → grant order 0,1,2,3. Then set `req`=1010 → order 1,3.
- Back-pressure: toggle `in_valid` and `out_rdy` randomly at 50% → results unchanged, no duplicated or dropped beats, `eng_data_out_en` only while `out_rdy[g]`.
- Request drop: deassert `req[2]` during LOAD → job still completes and `job_done[2]` pulses. Requester 2 is not granted again until it re-requests.
- Reset mid-DRAIN after 3 pops → all outputs 0 next cycle, `busy`=0, `job_cnt`=0. A new `req`=0001 then produces a correct job.
- Wrap: preload `job_cnt` by running 65536 jobs (or force) → wraps to 0. Values 0xFFFF+0x0001 → 0x0000.
